// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: legal active-low patterns, blank code,
// pattern decode and the monitor FSM state type.
package seg7_pkg;

  localparam int CNT_W = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  typedef struct packed {
    logic       legal;
    logic [3:0] digit;
  } seg7_dec_t;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } mon_state_t;

  function automatic seg7_dec_t seg7_decode(input logic [6:0] pattern);
    seg7_dec_t dec;
    dec = '{legal: 1'b1, digit: 4'h0};
    case (pattern)
      SEG_0:   dec.digit = 4'h0;
      SEG_1:   dec.digit = 4'h1;
      SEG_2:   dec.digit = 4'h2;
      SEG_3:   dec.digit = 4'h3;
      SEG_4:   dec.digit = 4'h4;
      SEG_5:   dec.digit = 4'h5;
      SEG_6:   dec.digit = 4'h6;
      SEG_7:   dec.digit = 4'h7;
      SEG_8:   dec.digit = 4'h8;
      SEG_9:   dec.digit = 4'h9;
      SEG_A:   dec.digit = 4'hA;
      SEG_B:   dec.digit = 4'hB;
      SEG_C:   dec.digit = 4'hC;
      SEG_D:   dec.digit = 4'hD;
      SEG_E:   dec.digit = 4'hE;
      SEG_F:   dec.digit = 4'hF;
      default: dec.legal = 1'b0;
    endcase
    return dec;
  endfunction

endpackage

// File: rtl/seg7_stable_filter.sv
// Two-flop synchronizer plus stability filter: a pattern is accepted once it has
// been seen STABLE_CYCLES consecutive strobes and differs from the last accepted one.
module seg7_stable_filter
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg_in,
  input  logic       sample_en,
  output logic       accept,
  output logic [6:0] pattern
);

  localparam logic [CNT_W-1:0] STABLE     = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] PRE_ACCEPT = CNT_W'(STABLE_CYCLES - 1);

  logic [6:0]       sync1;
  logic [6:0]       sync2;
  logic [6:0]       cand;
  logic [6:0]       acc_pat;
  logic [CNT_W-1:0] count;
  logic             match;

  // Accept is combinational so the top can register its outputs on the very
  // edge where the count reaches STABLE_CYCLES.
  always_comb begin
    match   = (sync2 == cand);
    accept  = sample_en && match && (count == PRE_ACCEPT) && (cand != acc_pat);
    pattern = cand;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1   <= '0;
      sync2   <= '0;
      cand    <= SEG_BLANK;
      acc_pat <= SEG_BLANK;
      count   <= '0;
    end else begin
      sync1 <= seg_in;
      sync2 <= sync1;
      if (sample_en) begin
        if (!match) begin
          cand  <= sync2;
          count <= CNT_W'(1);
        end else if (count < STABLE) begin
          count <= count + 1'b1;
        end
        if (accept) acc_pat <= cand;
      end
    end
  end

endmodule

// File: rtl/seg7_monitor.sv
// Seven-segment bus monitor: decodes filtered patterns, flags illegal codes and
// breaks in the mod-16 up-count, and keeps a saturating error count.
module seg7_monitor
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       seg_in,
  input  logic             sample_en,
  output logic [3:0]       value,
  output logic             value_valid,
  output logic             invalid,
  output logic             seq_err,
  output logic             locked,
  output logic [ERR_W-1:0] err_count
);

  logic       accept;
  logic [6:0] acc_pattern;
  seg7_dec_t  dec;
  mon_state_t state;
  mon_state_t state_next;
  logic [3:0] value_next;
  logic       valid_next;
  logic       invalid_next;
  logic       seq_next;

  seg7_stable_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk      (clk),
    .reset    (reset),
    .seg_in   (seg_in),
    .sample_en(sample_en),
    .accept   (accept),
    .pattern  (acc_pattern)
  );

  assign dec = seg7_decode(acc_pattern);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= UNLOCKED;
    else        state <= state_next;
  end

  // NOTE: each always_comb assigns defaults first so no path leaves a
  // variable unassigned and infers a latch.
  always_comb begin
    state_next = state;
    if (accept && dec.legal) state_next = LOCKED;
  end

  always_comb begin
    value_next   = value;
    valid_next   = 1'b0;
    invalid_next = 1'b0;
    seq_next     = 1'b0;
    if (accept) begin
      if (!dec.legal) begin
        invalid_next = 1'b1;
      end else begin
        valid_next = 1'b1;
        value_next = dec.digit;
        if (state == LOCKED && dec.digit != value + 4'd1) seq_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value       <= '0;
      value_valid <= 1'b0;
      invalid     <= 1'b0;
      seq_err     <= 1'b0;
      err_count   <= '0;
    end else begin
      value       <= value_next;
      value_valid <= valid_next;
      invalid     <= invalid_next;
      seq_err     <= seq_next;
      if ((invalid_next || seq_next) && err_count != '1)
        err_count <= err_count + 1'b1;
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_seg7_monitor.sv
// Scoreboard bench for seg7_monitor: a reference model pushes expected events
// when a pattern is driven; a negedge monitor pops and compares on each pulse.
module tb_seg7_monitor;

  localparam int STABLE = 4;
  localparam int ERR_W  = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [6:0]       seg_in = 7'h7F;
  logic             sample_en = 1'b1;
  logic [3:0]       value;
  logic             value_valid;
  logic             invalid;
  logic             seq_err;
  logic             locked;
  logic [ERR_W-1:0] err_count;

  seg7_monitor #(
    .STABLE_CYCLES(STABLE),
    .ERR_W        (ERR_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .seg_in     (seg_in),
    .sample_en  (sample_en),
    .value      (value),
    .value_valid(value_valid),
    .invalid    (invalid),
    .seq_err    (seq_err),
    .locked     (locked),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             valid;
    logic             inv;
    logic             seq;
    logic [3:0]       value;
    logic             locked;
    logic [ERR_W-1:0] err;
  } exp_t;

  exp_t sb[$];
  exp_t cur;

  int checks = 0;
  int errors = 0;
  int valid_pulses = 0;

  logic [6:0] digit_pat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic [6:0]       m_acc = 7'h7F;
  logic             m_locked = 1'b0;
  logic [3:0]       m_value = 4'h0;
  logic [ERR_W-1:0] m_err = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_acc    = 7'h7F;
    m_locked = 1'b0;
    m_value  = 4'h0;
    m_err    = '0;
  endfunction

  function automatic void model_accept(input logic [6:0] pat);
    int   d;
    exp_t e;
    if (pat == m_acc) return;
    m_acc = pat;
    d = -1;
    for (int i = 0; i < 16; i++) if (digit_pat[i] == pat) d = i;
    e.valid = 1'b0;
    e.inv   = 1'b0;
    e.seq   = 1'b0;
    if (d < 0) begin
      e.inv = 1'b1;
      if (m_err != '1) m_err = m_err + 1'b1;
    end else begin
      e.valid = 1'b1;
      if (m_locked && 4'(d) != 4'(m_value + 4'd1)) begin
        e.seq = 1'b1;
        if (m_err != '1) m_err = m_err + 1'b1;
      end
      m_value  = 4'(d);
      m_locked = 1'b1;
    end
    e.value  = m_value;
    e.locked = m_locked;
    e.err    = m_err;
    sb.push_back(e);
  endfunction

  task automatic hold(input logic [6:0] pat, input int n);
    @(negedge clk);
    seg_in = pat;
    if (n >= STABLE) model_accept(pat);
    repeat (n) @(posedge clk);
  endtask

  // Called right after a new pattern is driven on a negedge: the next posedge is edge 1.
  task automatic latency(input string tag);
    for (int e = 1; e <= STABLE + 2; e++) begin
      @(negedge clk);
      check(tag, 32'(value_valid), 32'(e == STABLE + 2));
    end
  endtask

  always @(negedge clk) begin
    if (reset && (value_valid || invalid || seq_err)) begin
      if (value_valid) valid_pulses++;
      if (sb.size() == 0) begin
        check("spurious_pulse", {29'd0, value_valid, invalid, seq_err}, 32'd0);
      end else begin
        cur = sb.pop_front();
        check("value_valid", 32'(value_valid), 32'(cur.valid));
        check("invalid",     32'(invalid),     32'(cur.inv));
        check("seq_err",     32'(seq_err),     32'(cur.seq));
        check("value",       32'(value),       32'(cur.value));
        check("locked",      32'(locked),      32'(cur.locked));
        check("err_count",   32'(err_count),   32'(cur.err));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #2;
    check("rst_value",  32'(value),       32'd0);
    check("rst_valid",  32'(value_valid), 32'd0);
    check("rst_locked", 32'(locked),      32'd0);
    check("rst_err",    32'(err_count),   32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // First accept: digit 0, latency STABLE+2 edges
    seg_in = 7'h40;
    model_accept(7'h40);
    latency("lat_first");
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("first_value",  32'(value),     32'd0);
    check("first_locked", 32'(locked),    32'd1);
    check("first_err",    32'(err_count), 32'd0);

    // Full up-count 1..F then wrap to 0
    for (int d = 1; d < 16; d++) hold(digit_pat[d], 10);
    hold(digit_pat[0], 10);
    repeat (3) @(negedge clk);
    check("valid_pulses_17", 32'(valid_pulses), 32'd17);
    check("count_err",       32'(err_count),    32'd0);

    // Skip from 3 to 5, then resume at 6
    hold(digit_pat[1], 10);
    hold(digit_pat[2], 10);
    hold(digit_pat[3], 10);
    hold(digit_pat[5], 10);
    check("skip_value", 32'(value),     32'd5);
    check("skip_err",   32'(err_count), 32'd1);
    hold(digit_pat[6], 10);
    check("resume_err", 32'(err_count), 32'd1);

    // Blank is illegal; short glitch between two identical patterns is ignored
    hold(7'h7F, 10);
    hold(7'h30, 10);
    hold(7'h24, 3);
    hold(7'h30, 10);
    check("glitch_value", 32'(value),     32'd3);
    check("glitch_err",   32'(err_count), 32'd3);

    // Saturate the error counter
    for (int i = 0; i < 300; i++) hold((i % 2) ? digit_pat[5] : digit_pat[0], STABLE + 2);
    repeat (4) @(negedge clk);
    check("sat_err", 32'(err_count), 32'd255);
    check("sb_empty_pre_reset", 32'(sb.size()), 32'd0);

    // Reset while a new pattern is at count 3
    @(negedge clk);
    seg_in = 7'h10;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_value",  32'(value),       32'd0);
    check("mid_rst_valid",  32'(value_valid), 32'd0);
    check("mid_rst_locked", 32'(locked),      32'd0);
    check("mid_rst_err",    32'(err_count),   32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_accept(7'h10);
    latency("lat_after_reset");
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("post_rst_value",  32'(value),     32'd9);
    check("post_rst_locked", 32'(locked),    32'd1);
    check("post_rst_err",    32'(err_count), 32'd0);

    check("sb_empty_end", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
